event_end_responder: RTL and testbench

- Responder side of the game_logic event handshake: game_logic raises event_flag, this block times the event and returns a single-cycle event_end_tick.
- Replaces the debounced Btn_R test stimulus in the game-logic test top.
- Also exports the latched event code, a seconds countdown for the FND and a blink strobe for ui_render/LED overlays.

---
 rtl/event_end_responder_if.sv | 32 +++
 rtl/event_end_responder.sv | 137 +++++++++++++
 tb/tb_event_end_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/event_end_responder_if.sv
// Event handshake bundle between game_logic (master) and event_end_responder
// (slave). The master drives the request and the skip button level; the
// responder returns the end tick plus status for the FND / LED overlays.
interface event_end_responder_if;
  logic [3:0] event_flag;
  logic       skip_btn;
  logic       event_end_tick;
  logic       event_active;
  logic [3:0] event_code;
  logic [3:0] remaining_sec;
  logic       blink;

  modport master (
    output event_flag,
    output skip_btn,
    input  event_end_tick,
    input  event_active,
    input  event_code,
    input  remaining_sec,
    input  blink
  );

  modport slave (
    input  event_flag,
    input  skip_btn,
    output event_end_tick,
    output event_active,
    output event_code,
    output remaining_sec,
    output blink
  );
endinterface

// File: rtl/event_end_responder.sv
// event_end_responder: times a game_logic event and answers with a one-cycle
// event_end_tick. A non-zero event_flag starts a EVENT_SEC * CYCLES_PER_SEC
// cycle run; dropping the flag to 0 aborts it silently. After the tick the
// block waits for the flag to clear so a stale request cannot retrigger.
// Optional feature macro: EVENT_SKIP_EN (rising edge of skip_btn in RUN ends
// the event early with a normal tick).
module event_end_responder #(
  parameter int CYCLES_PER_SEC = 100_000_000,
  parameter int EVENT_SEC      = 3
) (
  input  logic               clk,
  input  logic               reset,
  event_end_responder_if.slave bus
);

  // cyc_cnt width follows the cycles-per-second count; keep at least 1 bit
  localparam int            CW       = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_SEC - 1);
  localparam logic [CW:0]   CYC_HALF = (CW+1)'(CYCLES_PER_SEC / 2);
  localparam logic [3:0]    SEC_INIT = 4'(EVENT_SEC);
  // blink value for cyc_cnt == 0 (false only in the degenerate 1-cycle second)
  localparam logic          BLINK_0  = (CYC_HALF != '0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic          tick_q;
  logic          active_q;
  logic [3:0]    code_q;
  logic [3:0]    rem_q;
  logic          blink_q;

  logic          flag_set;
  logic          sec_last;
  logic          run_last;
  logic          skip_rise;
  logic [CW:0]   cyc_inc;

  assign flag_set = |bus.event_flag;
  assign sec_last = (cyc_cnt == CYC_LAST);
  // rem_q <= 1 rather than == 1 keeps remaining_sec from ever wrapping
  assign run_last = sec_last && (rem_q <= 4'd1);
  assign cyc_inc  = {1'b0, cyc_cnt} + (CW+1)'(1);

`ifdef EVENT_SKIP_EN
  logic skip_q;

  // Previous skip_btn level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) skip_q <= 1'b0;
    else       skip_q <= bus.skip_btn;
  end

  assign skip_rise = bus.skip_btn & ~skip_q;
`else
  logic unused_skip;

  // Skip input is not part of this build; the event always runs full length
  assign unused_skip = bus.skip_btn;
  assign skip_rise   = 1'b0;
`endif

  // Event FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
      code_q   <= 4'd0;
      rem_q    <= 4'd0;
      blink_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        IDLE: begin
          if (flag_set) begin
            state    <= RUN;
            code_q   <= bus.event_flag;
            rem_q    <= SEC_INIT;
            cyc_cnt  <= '0;
            active_q <= 1'b1;
            blink_q  <= BLINK_0;
          end
        end

        RUN: begin
          if (!flag_set) begin
            // Abort: game_logic withdrew the request, no tick
            state    <= IDLE;
            cyc_cnt  <= '0;
            active_q <= 1'b0;
            code_q   <= 4'd0;
            rem_q    <= 4'd0;
            blink_q  <= 1'b0;
          end else if (skip_rise || run_last) begin
            state    <= DONE;
            tick_q   <= 1'b1;
            cyc_cnt  <= '0;
            active_q <= 1'b0;
            rem_q    <= 4'd0;
            blink_q  <= 1'b0;
          end else if (sec_last) begin
            cyc_cnt <= '0;
            rem_q   <= rem_q - 4'd1;
            blink_q <= BLINK_0;
          end else begin
            cyc_cnt <= cyc_inc[CW-1:0];
            blink_q <= (cyc_inc < CYC_HALF);
          end
        end

        // Single tick cycle, then wait for the flag to be released
        DONE: state <= WAIT_CLR;

        WAIT_CLR: begin
          if (!flag_set) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.event_end_tick = tick_q;
  assign bus.event_active   = active_q;
  assign bus.event_code     = code_q;
  assign bus.remaining_sec  = rem_q;
  assign bus.blink          = blink_q;

endmodule

// File: tb/tb_event_end_responder.sv
// Self-checking bench for event_end_responder (CYCLES_PER_SEC=10,
// EVENT_SEC=2): directed scenarios followed by random traffic, all checked
// every cycle against an elapsed-time reference model.
module tb_event_end_responder;
  localparam int CPS   = 10;
  localparam int ES    = 2;
  localparam int TOTAL = CPS * ES;

  logic clk;
  logic reset;
  event_end_responder_if bus ();

  event_end_responder #(.CYCLES_PER_SEC(CPS), .EVENT_SEC(ES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int k;

  // Reference model: an event is "running" for TOTAL cycles of elapsed time
  bit         m_run, m_done, m_wait, m_prev_skip;
  int         m_el;
  logic [3:0] m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
`ifdef EVENT_SKIP_EN
    bit rise;
    rise = bus.skip_btn && !m_prev_skip;
`endif
    if (reset) begin
      m_run = 0; m_done = 0; m_wait = 0; m_el = 0; m_code = 0; m_prev_skip = 0;
    end else begin
      m_prev_skip = bus.skip_btn;
      if (m_run) begin
        if (bus.event_flag == 0) begin
          m_run = 0; m_code = 0;
        end
`ifdef EVENT_SKIP_EN
        else if (rise) begin
          m_run = 0; m_done = 1;
        end
`endif
        else begin
          m_el++;
          if (m_el == TOTAL) begin m_run = 0; m_done = 1; end
        end
      end else if (m_done) begin
        m_done = 0; m_wait = 1;
      end else if (m_wait) begin
        if (bus.event_flag == 0) m_wait = 0;
      end else if (bus.event_flag != 0) begin
        m_run = 1; m_el = 0; m_code = bus.event_flag;
      end
    end
  endtask

  task automatic check_all();
    chk("tick",   32'(bus.event_end_tick), 32'(m_done));
    chk("active", 32'(bus.event_active),   32'(m_run));
    chk("code",   32'(bus.event_code),     32'(m_code));
    chk("rem",    32'(bus.remaining_sec),  m_run ? 32'(ES - m_el / CPS) : 32'd0);
    chk("blink",  32'(bus.blink),          32'(m_run && ((m_el % CPS) < CPS / 2)));
  endtask

  // One clock: inputs already driven, advance DUT and model, check outputs
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic adv();
    step();
    k++;
  endtask

  task automatic run_to_tick();
    int n;
    n = 0;
    while (bus.event_end_tick !== 1'b1 && n < 60) begin
      adv();
      n++;
    end
  endtask

  logic [9:0] bp;

  initial begin
    clk = 0;
    reset = 1;
    bus.event_flag = 4'd0;
    bus.skip_btn = 1'b0;
    m_prev_skip = 0;
    repeat (3) step();
    chk("rst_active", 32'(bus.event_active), 32'd0);
    chk("rst_rem", 32'(bus.remaining_sec), 32'd0);
    reset = 0;
    step();

    // Basic event with code 5 held
    bus.event_flag = 4'd5;
    step(); k = 0;
    chk("start_active", 32'(bus.event_active), 32'd1);
    chk("start_code", 32'(bus.event_code), 32'd5);
    chk("start_rem", 32'(bus.remaining_sec), 32'd2);
    bp[0] = bus.blink;
    for (int i = 1; i < 10; i++) begin adv(); bp[i] = bus.blink; end
    chk("blink_pat", 32'(bp), 32'(10'b0000011111));
    adv();
    chk("rem_1s", 32'(bus.remaining_sec), 32'd1);
    run_to_tick();
    chk("tick_at", 32'(k), 32'd20);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_no_tick", 32'(bus.event_end_tick), 32'd0);
    end
    bus.event_flag = 4'd0;
    step();
    bus.event_flag = 4'd2;
    step(); k = 0;
    chk("restart_code", 32'(bus.event_code), 32'd2);
    run_to_tick();
    chk("tick2_at", 32'(k), 32'd20);
    bus.event_flag = 4'd0;
    repeat (2) step();

    // Abort at RUN cycle 7
    bus.event_flag = 4'd3;
    step(); k = 0;
    while (k < 6) adv();
    bus.event_flag = 4'd0;
    adv();
    chk("abort_active", 32'(bus.event_active), 32'd0);
    chk("abort_code", 32'(bus.event_code), 32'd0);
    bp[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin step(); if (bus.event_end_tick) bp[0] = 1'b1; end
    chk("abort_no_tick", 32'(bp[0]), 32'd0);

    // Reset at RUN cycle 12, flag held through and after reset
    bus.event_flag = 4'd6;
    step(); k = 0;
    while (k < 11) adv();
    reset = 1;
    step();
    chk("midrst_active", 32'(bus.event_active), 32'd0);
    chk("midrst_tick", 32'(bus.event_end_tick), 32'd0);
    reset = 0;
    step(); k = 0;
    chk("rst_restart_rem", 32'(bus.remaining_sec), 32'd2);
    run_to_tick();
    chk("tick3_at", 32'(k), 32'd20);
    bus.event_flag = 4'd0;
    repeat (2) step();

    // Flag changes mid-run from 1 to 9
    bus.event_flag = 4'd1;
    step(); k = 0;
    while (k < 3) adv();
    bus.event_flag = 4'd9;
    run_to_tick();
    chk("chg_tick_at", 32'(k), 32'd20);
    chk("chg_code", 32'(bus.event_code), 32'd1);
    bus.event_flag = 4'd0;
    repeat (2) step();

    // skip_btn already high at event start: full duration
    bus.skip_btn = 1'b1;
    step();
    bus.event_flag = 4'd4;
    step(); k = 0;
    run_to_tick();
    chk("skip_held_tick_at", 32'(k), 32'd20);
    bus.event_flag = 4'd0;
    bus.skip_btn = 1'b0;
    repeat (2) step();

    // skip_btn rising edge sampled at RUN cycle 6
    bus.event_flag = 4'd7;
    step(); k = 0;
    while (k < 6) adv();
    bus.skip_btn = 1'b1;
    run_to_tick();
`ifdef EVENT_SKIP_EN
    chk("skip_tick_at", 32'(k), 32'd7);
`else
    chk("skip_tick_at", 32'(k), 32'd20);
`endif
    bus.event_flag = 4'd0;
    bus.skip_btn = 1'b0;
    repeat (2) step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) bus.event_flag = 4'd0;
      else if (r < 6 || (bus.event_flag == 0 && r < 30))
        bus.event_flag = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) bus.skip_btn = ~bus.skip_btn;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
